// File: rtl/axi_drain_gate.sv
// AXI drain gate: counts outstanding writes/reads and gates new AW/AR so traffic can be drained.
// Optional macro AXI_DRAIN_GATE_CNT_OUT_EN exports the outstanding counters on wr_cnt_o/rd_cnt_o.

package axi_drain_gate_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

endpackage

module axi_drain_gate #(
    parameter int unsigned MaxTxns = 32'd8,
    parameter type axi_req_t  = axi_drain_gate_pkg::axi_req_t,
    parameter type axi_resp_t = axi_drain_gate_pkg::axi_resp_t,
    localparam int unsigned CntW = $clog2(MaxTxns + 32'd1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            drain_i,
    output logic            drained_o,
    input  axi_req_t        slv_req_i,
    output axi_resp_t       slv_resp_o,
    output axi_req_t        mst_req_o,
    input  axi_resp_t       mst_resp_i,
    output logic [CntW-1:0] wr_cnt_o,
    output logic [CntW-1:0] rd_cnt_o
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DRAINING = 2'd1,
        ST_DRAINED  = 2'd2
    } state_e;

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

    state_e          state_r, state_s;
    logic [CntW-1:0] wr_cnt_r, wr_cnt_s;
    logic [CntW-1:0] rd_cnt_r, rd_cnt_s;
    logic            aw_pend_r, aw_pend_s;
    logic            ar_pend_r, ar_pend_s;
    logic            drained_r;
    logic            aw_open_s, ar_open_s;
    logic            aw_hs_s, ar_hs_s, b_hs_s, r_last_hs_s;

    // Saturating up/down counter step; simultaneous inc and dec cancel out.
    function automatic logic [CntW-1:0] cnt_update(input logic [CntW-1:0] cnt,
                                                   input logic inc, input logic dec);
        logic [CntW-1:0] res;
        if (inc && !dec) begin
            res = cnt + CntW'(1'b1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CntW'(1'b1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Gate open decision from registered state; a pending request stays open to keep valid stable.
    always_comb begin
        aw_open_s = aw_pend_r || ((wr_cnt_r != MaxCnt) && (state_r == ST_NORMAL));
        ar_open_s = ar_pend_r || ((rd_cnt_r != MaxCnt) && (state_r == ST_NORMAL));
    end

    // Pass-through of all channels with only the AW/AR valid/ready pairs gated.
    always_comb begin
        mst_req_o           = slv_req_i;
        slv_resp_o          = mst_resp_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open_s;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open_s;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open_s;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open_s;
    end

    // Handshake detection, counter and pending-flag next values.
    always_comb begin
        aw_hs_s     = slv_req_i.aw_valid & aw_open_s & mst_resp_i.aw_ready;
        ar_hs_s     = slv_req_i.ar_valid & ar_open_s & mst_resp_i.ar_ready;
        b_hs_s      = mst_resp_i.b_valid & slv_req_i.b_ready;
        r_last_hs_s = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
        wr_cnt_s    = cnt_update(wr_cnt_r, aw_hs_s, b_hs_s);
        rd_cnt_s    = cnt_update(rd_cnt_r, ar_hs_s, r_last_hs_s);
        if (aw_hs_s) begin
            aw_pend_s = 1'b0;
        end else if (slv_req_i.aw_valid && aw_open_s) begin
            aw_pend_s = 1'b1;
        end else begin
            aw_pend_s = aw_pend_r;
        end
        if (ar_hs_s) begin
            ar_pend_s = 1'b0;
        end else if (slv_req_i.ar_valid && ar_open_s) begin
            ar_pend_s = 1'b1;
        end else begin
            ar_pend_s = ar_pend_r;
        end
    end

    // Drain state machine next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (drain_i) begin
                    state_s = ST_DRAINING;
                end else begin
                    state_s = ST_NORMAL;
                end
            end
            ST_DRAINING: begin
                if (!drain_i) begin
                    state_s = ST_NORMAL;
                end else if ((wr_cnt_r == '0) && (rd_cnt_r == '0) && !aw_pend_r && !ar_pend_r
                             && !aw_hs_s && !ar_hs_s) begin
                    state_s = ST_DRAINED;
                end else begin
                    state_s = ST_DRAINING;
                end
            end
            ST_DRAINED: begin
                if (!drain_i) begin
                    state_s = ST_NORMAL;
                end else begin
                    state_s = ST_DRAINED;
                end
            end
            default: state_s = ST_NORMAL;
        endcase
    end

    // State, counters, pending flags and drained flag registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= ST_NORMAL;
            wr_cnt_r  <= '0;
            rd_cnt_r  <= '0;
            aw_pend_r <= 1'b0;
            ar_pend_r <= 1'b0;
            drained_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_cnt_r  <= wr_cnt_s;
            rd_cnt_r  <= rd_cnt_s;
            aw_pend_r <= aw_pend_s;
            ar_pend_r <= ar_pend_s;
            drained_r <= (state_s == ST_DRAINED);
        end
    end

    assign drained_o = drained_r;

`ifdef AXI_DRAIN_GATE_CNT_OUT_EN
    assign wr_cnt_o = wr_cnt_r;
    assign rd_cnt_o = rd_cnt_r;
`else
    assign wr_cnt_o = '0;
    assign rd_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_drain_gate.sv
// Directed scoreboard bench for axi_drain_gate with MaxTxns=2.
// Expected counter values honour AXI_DRAIN_GATE_CNT_OUT_EN (zero when the macro is undefined).

module tb_axi_drain_gate;

    import axi_drain_gate_pkg::*;

    logic       clk;
    logic       rst_ni;
    logic       drain_i;
    logic       drained_o;
    axi_req_t   slv_req;
    axi_resp_t  slv_resp;
    axi_req_t   mst_req;
    axi_resp_t  mst_resp;
    logic [1:0] wr_cnt;
    logic [1:0] rd_cnt;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];
    string      tag_q[$];

    axi_drain_gate #(
        .MaxTxns    (32'd2),
        .axi_req_t  (axi_req_t),
        .axi_resp_t (axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .drain_i    (drain_i),
        .drained_o  (drained_o),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .wr_cnt_o   (wr_cnt),
        .rd_cnt_o   (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ec(input int v);
`ifdef AXI_DRAIN_GATE_CNT_OUT_EN
        return 2'(v);
`else
        return 2'd0;
`endif
    endfunction

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic compare_pop();
        logic [8:0] obs;
        logic [8:0] exp;
        string      t;
        obs = {drained_o, mst_req.aw_valid, mst_req.ar_valid,
               slv_resp.aw_ready, slv_resp.ar_ready, wr_cnt, rd_cnt};
        exp = sb_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", t, obs, exp);
        end
    endtask

    // d = {drain, s_awv, m_awr, s_arv, m_arr, b_valid, r_valid, r_last}
    // f = {drained, m_awv, m_arv, s_awr, s_arr}
    task automatic step(input string tag, input logic [7:0] d, input logic [4:0] f,
                        input int wc, input int rc);
        @(negedge clk);
        {drain_i, slv_req.aw_valid, mst_resp.aw_ready, slv_req.ar_valid,
         mst_resp.ar_ready, mst_resp.b_valid, mst_resp.r_valid, mst_resp.r.last} = d;
        sb_q.push_back({f, ec(wc), ec(rc)});
        tag_q.push_back(tag);
        #2;
        compare_pop();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        {drain_i, slv_req.aw_valid, mst_resp.aw_ready, slv_req.ar_valid,
         mst_resp.ar_ready, mst_resp.b_valid, mst_resp.r_valid, mst_resp.r.last} = 8'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sb_q.push_back({5'b00000, 2'd0, 2'd0});
        tag_q.push_back("in_reset");
        #2;
        compare_pop();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni   = 1'b0;
        drain_i  = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready = 1'b1;
        slv_req.r_ready = 1'b1;
        apply_reset();

        step("reset_idle", 8'b0000_0000, 5'b00000, 0, 0);

        // Payload pass-through
        @(negedge clk);
        slv_req.aw.addr    = 32'hDEAD_BEEF;
        slv_req.w.data     = 32'h1234_5678;
        mst_resp.r.data    = 32'hCAFE_F00D;
        #2;
        checks++;
        assert (mst_req.aw.addr === 32'hDEAD_BEEF) else begin
            errors++;
            $error("FAIL aw_addr observed %h expected %h", mst_req.aw.addr, 32'hDEAD_BEEF);
        end
        checks++;
        assert (mst_req.w.data === 32'h1234_5678) else begin
            errors++;
            $error("FAIL w_data observed %h expected %h", mst_req.w.data, 32'h1234_5678);
        end
        checks++;
        assert (slv_resp.r.data === 32'hCAFE_F00D) else begin
            errors++;
            $error("FAIL r_data observed %h expected %h", slv_resp.r.data, 32'hCAFE_F00D);
        end

        // Limit of two outstanding writes
        step("aw1",         8'b0110_0000, 5'b01010, 0, 0);
        step("aw2",         8'b0110_0000, 5'b01010, 1, 0);
        step("aw3_block",   8'b0110_0000, 5'b00000, 2, 0);
        step("aw3_block_b", 8'b0110_0100, 5'b00000, 2, 0);
        step("aw3_go",      8'b0110_0000, 5'b01010, 1, 0);
        step("wr_full",     8'b0000_0000, 5'b00000, 2, 0);
        step("b1",          8'b0000_0100, 5'b00000, 2, 0);
        step("b2",          8'b0000_0100, 5'b00000, 1, 0);
        step("b_at_zero",   8'b0000_0100, 5'b00000, 0, 0);
        step("wr_sat",      8'b0000_0000, 5'b00000, 0, 0);

        // Drain with one write and one read outstanding
        step("ar1",         8'b0001_1000, 5'b00101, 0, 0);
        step("r_nolast",    8'b0000_0010, 5'b00000, 0, 1);
        step("aw_out",      8'b0110_0000, 5'b01010, 0, 1);
        step("drain_rise",  8'b1000_0000, 5'b00000, 1, 1);
        step("drain_block", 8'b1111_1000, 5'b00000, 1, 1);
        step("drain_b",     8'b1111_1100, 5'b00000, 1, 1);
        step("drain_rlast", 8'b1111_1011, 5'b00000, 0, 1);
        step("drain_zero",  8'b1111_1000, 5'b00000, 0, 0);
        step("drained",     8'b1000_0000, 5'b10000, 0, 0);
        step("release",     8'b0000_0000, 5'b10000, 0, 0);
        step("normal",      8'b0000_0000, 5'b00000, 0, 0);

        // Stalled AW when drain rises keeps valid until accepted
        step("stall_drain", 8'b1100_0000, 5'b01000, 0, 0);
        step("stall_held",  8'b1100_0000, 5'b01000, 0, 0);
        step("stall_hs",    8'b1111_1000, 5'b01010, 0, 0);
        step("post_hs",     8'b1111_1000, 5'b00000, 1, 0);
        step("stall_b",     8'b1000_0100, 5'b00000, 1, 0);
        step("stall_zero",  8'b1000_0000, 5'b00000, 0, 0);
        step("stall_drnd",  8'b1000_0000, 5'b10000, 0, 0);
        step("stall_rel",   8'b0000_0000, 5'b10000, 0, 0);
        step("stall_norm",  8'b0000_0000, 5'b00000, 0, 0);

        // Simultaneous AW and B at count 1
        step("sim_aw",      8'b0110_0000, 5'b01010, 0, 0);
        step("sim_aw_b",    8'b0110_0100, 5'b01010, 1, 0);
        step("sim_hold",    8'b0000_0000, 5'b00000, 1, 0);
        step("sim_b",       8'b0000_0100, 5'b00000, 1, 0);
        step("sim_idle",    8'b0000_0000, 5'b00000, 0, 0);

        // Reset mid-burst discards counts and drain state
        step("mid_aw",      8'b0110_0000, 5'b01010, 0, 0);
        step("mid_ar",      8'b0001_1000, 5'b00101, 1, 0);
        step("mid_drain",   8'b1000_0000, 5'b00000, 1, 1);
        apply_reset();
        step("post_rst",    8'b0000_0000, 5'b00000, 0, 0);
        step("post_rst_aw", 8'b0110_0000, 5'b01010, 0, 0);
        step("post_rst_c",  8'b0000_0000, 5'b00000, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
